inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Circular instruction queue between the fetch stage and decode/dispatch.
- Each entry holds a fetched instruction word plus its pc and pc_next.
- Presents the head entry show-ahead to decode and asserts full back to fetch.
- Flushed as a whole on a resolved branch redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all entries (branch redirect)
- enq  input  1  write request from fetch
- enq_inst  input  32  instruction word to write
- enq_pc  input  32  pc of that instruction
- enq_pc_next  input  32  pc+4 of that instruction
- full  output  1  queue holds DEPTH valid entries
- deq  input  1  read request from decode
- empty  output  1  queue holds no valid entries
- deq_inst  output  32  head instruction word
- deq_pc  output  32  head pc
- deq_pc_next  output  32  head pc_next
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage:
  - DEPTH-entry array of {inst, pc, pc_next}, 96 bits per entry.
  - Write pointer wptr and read pointer rptr, each PTR_W bits, wrap modulo DEPTH.
  - Occupancy register cnt, PTR_W+1 bits.
- Reset (rst high at posedge):
  - wptr=0, rptr=0, cnt=0.
  - Next cycle: full=0, empty=1, count=0, deq_* = 0.
  - Array contents are not reset.
  - rst overrides flush, enq and deq in the same cycle.
- Status outputs:
  - full = (cnt==DEPTH); empty = (cnt==0); count = cnt.
  - All are functions of registered state only, with no combinational path from enq/deq.
- Read data:
  - Show-ahead: deq_* reflect entry[rptr] combinationally from state.
  - Forced to 0 when empty.
  - deq_* are valid in the same cycle deq is sampled; there is no read latency.
- Accepted enq (enq && !full):
  - Writes entry[wptr] at posedge; wptr increments.
  - The entry is visible at the head no earlier than the following cycle; no same-cycle bypass through an empty queue.
- Accepted deq (deq && !empty):
  - rptr increments at posedge.
  - The next entry appears on deq_* the following cycle.
- Occupancy update: cnt_next = cnt + accepted_enq - accepted_deq.
  - Simultaneous accepted enq and deq leaves cnt unchanged; both pointers advance.
- Full boundary:
  - enq while full is ignored (no write, no pointer change), even if deq is asserted the same cycle.
  - Fetch must hold the instruction until full deasserts.
- Empty boundary:
  - deq while empty is ignored.
  - A simultaneous enq is still accepted.
- Wrap-around:
  - Pointers roll from DEPTH-1 to 0 with no bubble.
  - Ordering is strictly FIFO across the wrap.
- Flush:
  - At posedge: wptr=0, rptr=0, cnt=0; same-cycle enq and deq are ignored.
  - Next cycle: empty=1, full=0.
  - Fetch enqueues the redirected-pc instruction no earlier than the cycle after flush.
- Invalid request handling: requests rejected by the full/empty rules are dropped silently; there is no error output.
- Assertions (simulation only):
  - cnt never exceeds DEPTH.
  - cnt == (wptr - rptr) mod DEPTH, except when full, where wptr==rptr.

Test Plan:
- Reset, then fill and drain (DEPTH=4):
  - After reset: empty=1, count=0, deq_inst=0.
  - Enqueue inst 0x00000013/0x00100093/0x00200113/0x00300193 at pc 0x60000000..0x6000000C, one per cycle.
  - Cycle after 4th enq: full=1, count=4.
  - Dequeue 4 in order: deq_pc 0x60000000, 0x60000004, 0x60000008, 0x6000000C with matching inst and pc_next=pc+4; then empty=1.
- Overflow:
  - With queue full, assert enq (inst 0xDEADBEEF) and deq together.
  - count goes 4->3; 0xDEADBEEF never appears at the head.
- Underflow:
  - With queue empty, assert deq for 3 cycles: count stays 0, pointers unchanged.
  - Then enq 0x00000013: empty=0 next cycle, deq_inst=0x00000013.
- Simultaneous enq/deq with count=2:
  - count stays 2 for 10 consecutive cycles.
  - Dequeue order matches enqueue order across at least two pointer wraps.
- Flush:
  - With count=3, assert flush together with enq and deq.
  - Next cycle: empty=1, count=0, deq_*=0.
  - Following enq at pc 0x60000100 is the head the cycle after.
- Reset mid-operation:
  - With count=2, assert rst and flush together.
  - Next cycle: empty=1, full=0, count=0; normal enqueue resumes afterwards.

Source files
------------

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode.
// Show-ahead head entry; whole-queue flush on branch redirect.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq,
    input  logic [31:0]      enq_inst,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_pc_next,
    output logic             full,
    input  logic             deq,
    output logic             empty,
    output logic [31:0]      deq_inst,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_pc_next,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } iq_entry_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   cnt;
    logic [PTR_W:0]   cnt_next;
    logic             do_enq;
    logic             do_deq;
    iq_entry_t        head;

    assign full   = (cnt == DEPTH_C);
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;

    always_comb begin
        cnt_next = cnt;
        unique case ({do_enq, do_deq})
            2'b10:   cnt_next = cnt + (PTR_W+1)'(1);
            2'b01:   cnt_next = cnt - (PTR_W+1)'(1);
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_enq) wptr <= wptr + PTR_W'(1);
            if (do_deq) rptr <= rptr + PTR_W'(1);
            cnt <= cnt_next;
        end
    end

    // Storage is not reset; empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_enq)
            mem[wptr] <= '{inst: enq_inst, pc: enq_pc, pc_next: enq_pc_next};
    end

    always_comb begin
        head = mem[rptr];
        if (empty) head = '0;
    end

    assign deq_inst    = head.inst;
    assign deq_pc      = head.pc;
    assign deq_pc_next = head.pc_next;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt <= DEPTH_C)
                else $error("inst_queue: occupancy above DEPTH");
            assert (PTR_W'(wptr - rptr) == cnt[PTR_W-1:0])
                else $error("inst_queue: pointers disagree with occupancy");
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed testbench for inst_queue with DEPTH=4.
// Each scenario task checks its own results inline.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 0;
    logic             rst, flush, enq, deq;
    logic [31:0]      enq_inst, enq_pc, enq_pc_next;
    logic             full, empty;
    logic [31:0]      deq_inst, deq_pc, deq_pc_next;
    logic [PTR_W:0]   count;

    int tests = 0;
    int fails = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq(enq), .enq_inst(enq_inst), .enq_pc(enq_pc),
        .enq_pc_next(enq_pc_next), .full(full),
        .deq(deq), .empty(empty), .deq_inst(deq_inst),
        .deq_pc(deq_pc), .deq_pc_next(deq_pc_next), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [31:0] inst, input logic [31:0] pc);
        enq = 1; enq_inst = inst; enq_pc = pc; enq_pc_next = pc + 32'd4;
    endtask

    task automatic idle();
        enq = 0; deq = 0; flush = 0; rst = 0;
        enq_inst = 0; enq_pc = 0; enq_pc_next = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: empty=%b full=%b, need empty=1 full=0", empty, full);
        end
        tests++;
        if (count !== 3'd0 || deq_inst !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: count=%0d deq_inst=%h, need 0 and 0", count, deq_inst);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] inst, pc;
        for (int i = 0; i < 4; i++) begin
            drive_enq(32'h0000_0013 + 32'h0010_0080 * i, 32'h6000_0000 + 4 * i);
            step();
        end
        idle();
        tests++;
        if (full !== 1'b1 || count !== 3'd4) begin
            fails++;
            $display("FAIL fill_full: full=%b count=%0d, need full=1 count=4", full, count);
        end
        for (int i = 0; i < 4; i++) begin
            inst = 32'h0000_0013 + 32'h0010_0080 * i;
            pc   = 32'h6000_0000 + 4 * i;
            tests++;
            if (deq_inst !== inst || deq_pc !== pc || deq_pc_next !== pc + 32'd4) begin
                fails++;
                $display("FAIL drain_%0d: got %h/%h/%h, need %h/%h/%h", i,
                         deq_inst, deq_pc, deq_pc_next, inst, pc, pc + 32'd4);
            end
            deq = 1;
            step();
        end
        idle();
        tests++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            fails++;
            $display("FAIL drain_empty: empty=%b count=%0d, need 1 and 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            drive_enq(32'h0000_00A0 + i, 32'h6000_0020 + 4 * i);
            step();
        end
        drive_enq(32'hDEAD_BEEF, 32'h6000_0040);
        deq = 1;
        step();
        idle();
        tests++;
        if (count !== 3'd3 || full !== 1'b0) begin
            fails++;
            $display("FAIL overflow_count: count=%0d full=%b, need 3 and 0", count, full);
        end
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (deq_inst !== 32'h0000_00A0 + i) begin
                fails++;
                $display("FAIL overflow_head_%0d: got %h, need %h", i, deq_inst, 32'h0000_00A0 + i);
            end
            deq = 1;
            step();
        end
        idle();
        tests++;
        if (empty !== 1'b1 || deq_inst === 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL overflow_drop: empty=%b deq_inst=%h, need empty=1", empty, deq_inst);
        end
    endtask

    task automatic test_underflow();
        deq = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (count !== 3'd0 || empty !== 1'b1) begin
                fails++;
                $display("FAIL underflow_%0d: count=%0d empty=%b, need 0 and 1", i, count, empty);
            end
        end
        drive_enq(32'h0000_0013, 32'h6000_0050);
        step();
        idle();
        tests++;
        if (empty !== 1'b0 || count !== 3'd1 || deq_inst !== 32'h0000_0013
            || deq_pc !== 32'h6000_0050) begin
            fails++;
            $display("FAIL underflow_enq: empty=%b count=%0d inst=%h pc=%h, need 0/1/00000013/60000050",
                     empty, count, deq_inst, deq_pc);
        end
        deq = 1;
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive_enq(32'h0000_1000 + i, 32'h6000_0080 + 4 * i);
            exp_q.push_back(32'h0000_1000 + i);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            drive_enq(32'h0000_1002 + k, 32'h6000_0088 + 4 * k);
            deq = 1;
            exp = exp_q.pop_front();
            exp_q.push_back(32'h0000_1002 + k);
            tests++;
            if (count !== 3'd2 || deq_inst !== exp) begin
                fails++;
                $display("FAIL b2b_%0d: count=%0d inst=%h, need 2 and %h", k, count, deq_inst, exp);
            end
            step();
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            exp = exp_q.pop_front();
            tests++;
            if (deq_inst !== exp) begin
                fails++;
                $display("FAIL b2b_tail_%0d: got %h, need %h", k, deq_inst, exp);
            end
            deq = 1;
            step();
        end
        idle();
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_empty: empty=%b, need 1", empty);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive_enq(32'h0000_2000 + i, 32'h6000_00C0 + 4 * i);
            step();
        end
        tests++;
        if (count !== 3'd3) begin
            fails++;
            $display("FAIL flush_pre: count=%0d, need 3", count);
        end
        drive_enq(32'h0000_0BAD, 32'h6000_00F0);
        deq = 1;
        flush = 1;
        step();
        idle();
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL flush_flags: empty=%b full=%b count=%0d, need 1/0/0", empty, full, count);
        end
        tests++;
        if (deq_inst !== 32'd0 || deq_pc !== 32'd0 || deq_pc_next !== 32'd0) begin
            fails++;
            $display("FAIL flush_data: got %h/%h/%h, need zeros", deq_inst, deq_pc, deq_pc_next);
        end
        drive_enq(32'h0000_0517, 32'h6000_0100);
        step();
        idle();
        tests++;
        if (deq_pc !== 32'h6000_0100 || deq_inst !== 32'h0000_0517
            || deq_pc_next !== 32'h6000_0104 || count !== 3'd1) begin
            fails++;
            $display("FAIL flush_redirect: pc=%h inst=%h pcn=%h count=%0d, need 60000100/00000517/60000104/1",
                     deq_pc, deq_inst, deq_pc_next, count);
        end
        deq = 1;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive_enq(32'h0000_3000 + i, 32'h6000_0180 + 4 * i);
            step();
        end
        idle();
        rst = 1;
        flush = 1;
        step();
        idle();
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL rst_mid: empty=%b full=%b count=%0d, need 1/0/0", empty, full, count);
        end
        drive_enq(32'h0000_3333, 32'h6000_0200);
        step();
        idle();
        tests++;
        if (deq_inst !== 32'h0000_3333 || deq_pc !== 32'h6000_0200 || count !== 3'd1) begin
            fails++;
            $display("FAIL rst_resume: inst=%h pc=%h count=%0d, need 00003333/60000200/1",
                     deq_inst, deq_pc, count);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
